dnd_event_classifier: RTL
=========================

Name: dnd_event_classifier

Overview:
- Sits directly downstream of the MLP denoiser top.
- Buffers each CAVIAR event as it enters the activation/MLP path.
- Pairs each buffered event in order with the MLP score (`out`/`out_vld`) when that score returns.
- Compares the score against a programmable threshold and forwards signal events on a valid/ready stream; drops noise events and counts both classes.

Parameters:
- CAVIAR_X_Y_BITS, 9, x/y field width; event word is 2*CAVIAR_X_Y_BITS+1 bits {pol, y, x}.
- W_Y, 17, MLP score width; two's-complement signed.
- DEPTH, 8, pending-event FIFO depth; power of two, >= 2.
- W_CNT, 16, width of the signal/noise statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- evt_in  in  2*CAVIAR_X_Y_BITS+1  event being issued to the MLP path.
- evt_in_vld  in  1  evt_in valid.
- evt_in_rdy  out  1  pending FIFO can accept.
- score  in  W_Y  MLP output score, signed.
- score_vld  in  1  score valid (MLP has no backpressure).
- threshold  in  W_Y  signed decision threshold, quasi-static.
- evt_out  out  2*CAVIAR_X_Y_BITS+1  classified event.
- evt_out_vld  out  1  evt_out valid.
- evt_out_rdy  in  1  downstream accepts.
- evt_out_is_sig  out  1  1 = signal event.
- sig_cnt  out  W_CNT  saturating count of signal decisions.
- noise_cnt  out  W_CNT  saturating count of noise decisions.
- err_orphan  out  1  sticky: a score arrived with the FIFO empty.
- err_ovf  out  1  sticky: a signal event was lost because the output register was occupied.

Behaviour:
- Reset values: FIFO empty, evt_in_rdy=1, evt_out=0, evt_out_vld=0, evt_out_is_sig=0, counters=0, both error flags=0.
- Reset mid-operation discards all pending and output contents; no partial output.
- Push: on evt_in_vld && evt_in_rdy, evt_in is written at the tail.
- evt_in_rdy = !full. It is registered-state derived only; it does not depend on score_vld in the same cycle.
- Pop: on score_vld with the FIFO not empty, the head is popped.
  - Decision: is_sig = ($signed(score) >= $signed(threshold)); the comparison is full W_Y signed.
- Simultaneous push and pop (not full) are both performed; occupancy is unchanged.
- score_vld with the FIFO empty, including the cycle of the first push: the score is dropped, err_orphan is set, and no counter changes.
- Output register, one entry; latency is 1 cycle (score_vld at cycle N gives evt_out_vld at N+1).
  - Load when the decision yields an emit and the register is empty or being drained the same cycle (evt_out_vld && evt_out_rdy).
  - Emit while the register is occupied and not draining: the event is lost, err_ovf is set, and it is still counted.
  - evt_out_vld clears on handshake unless reloaded in the same cycle.
  - evt_out is stable while evt_out_vld && !evt_out_rdy.
- Counters: sig_cnt or noise_cnt increments by 1 per decision and saturates at all-ones (no wrap).
- Error flags clear only on rst.
- FIFO pointers use $clog2(DEPTH)+1 bits; wrap-around is transparent; full/empty come from the MSB compare.

Optional Feature:
- Macro: DND_PASS_NOISE_EN.
- Defined: every decision emits; noise events go out with evt_out_is_sig=0 and follow the same output/overflow rules.
- Undefined: only signal events emit; noise events are counted and discarded; evt_out_is_sig is tied 1 whenever evt_out_vld=1 (0 at reset).

Test Plan:
1. Basic pass:
   - Stimulus: threshold=0; push event {pol=1,y=5,x=7}; 3 cycles later score=100; evt_out_rdy=1.
   - Response: evt_out=that event at score_vld+1 for 1 cycle; sig_cnt=1.
2. Noise drop:
   - Stimulus: threshold=0; push 2 events; scores -1 then 0.
   - Response: first counted noise with nothing emitted (macro off); second emitted, since >= is inclusive; sig_cnt=1, noise_cnt=1.
   - With DND_PASS_NOISE_EN: both emitted, is_sig=0 then 1.
3. FIFO full/order:
   - Stimulus: DEPTH=8; push 8 events with no scores.
   - Response: evt_in_rdy=0 after the 8th push; a 9th offered event is not accepted.
   - Then apply 8 scores of +1: outputs appear in push order, and evt_in_rdy returns 1 the cycle after the first pop.
4. Orphan:
   - Stimulus: score_vld with FIFO empty.
   - Response: err_orphan=1, counters unchanged, no output; flag persists until rst.
5. Backpressure overflow:
   - Stimulus: evt_out_rdy=0; two signal scores on consecutive cycles.
   - Response: first held on evt_out, unchanged; second lost, err_ovf=1, sig_cnt=2.
6. Saturation/reset:
   - Stimulus: W_CNT=4; 20 signal decisions, then rst asserted for 1 cycle mid-stream.
   - Response: sig_cnt stops at 15; after rst all outputs return to reset values and evt_in_rdy=1.

Source files
------------

// File: rtl/dnd_event_classifier.sv
// Pairs buffered CAVIAR events with returning MLP scores, thresholds them and forwards signal events.
// Optional build macro DND_PASS_NOISE_EN: noise events are also forwarded, flagged with evt_out_is_sig=0.
module dnd_event_classifier #(
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int W_Y             = 17,
  parameter int DEPTH           = 8,
  parameter int W_CNT           = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*CAVIAR_X_Y_BITS:0]   evt_in,
  input  logic                         evt_in_vld,
  output logic                         evt_in_rdy,
  input  logic [W_Y-1:0]               score,
  input  logic                         score_vld,
  input  logic [W_Y-1:0]               threshold,
  output logic [2*CAVIAR_X_Y_BITS:0]   evt_out,
  output logic                         evt_out_vld,
  input  logic                         evt_out_rdy,
  output logic                         evt_out_is_sig,
  output logic [W_CNT-1:0]             sig_cnt,
  output logic [W_CNT-1:0]             noise_cnt,
  output logic                         err_orphan,
  output logic                         err_ovf
);

  localparam int W_EVT = 2*CAVIAR_X_Y_BITS + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int W_PTR = AW + 1;

  logic [W_EVT-1:0] mem [DEPTH];
  logic [W_PTR-1:0] wr_ptr, rd_ptr;
  logic             empty, full;
  logic             push, pop, orphan;
  logic             is_sig, emit, drain, load, ovf;
  logic [W_EVT-1:0] head;
  logic             sig_r;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign evt_in_rdy = !full;
  assign push       = evt_in_vld && !full;
  assign pop        = score_vld && !empty;
  assign orphan     = score_vld && empty;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign is_sig     = ($signed(score) >= $signed(threshold));

`ifdef DND_PASS_NOISE_EN
  assign emit = pop;
`else
  assign emit = pop && is_sig;
`endif

  assign drain = evt_out_vld && evt_out_rdy;
  assign load  = emit && (!evt_out_vld || evt_out_rdy);
  assign ovf   = emit && evt_out_vld && !evt_out_rdy;

  assign evt_out_is_sig = evt_out_vld && sig_r;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= evt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + W_PTR'(1);
      if (pop)  rd_ptr <= rd_ptr + W_PTR'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_out     <= '0;
      evt_out_vld <= 1'b0;
      sig_r       <= 1'b0;
    end else if (load) begin
      evt_out     <= head;
      evt_out_vld <= 1'b1;
      sig_r       <= is_sig;
    end else if (drain) begin
      evt_out_vld <= 1'b0;
    end
  end

  // Counters saturate at all-ones; lost events are still counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_cnt   <= '0;
      noise_cnt <= '0;
    end else if (pop) begin
      if (is_sig) begin
        if (sig_cnt != {W_CNT{1'b1}}) sig_cnt <= sig_cnt + W_CNT'(1);
      end else begin
        if (noise_cnt != {W_CNT{1'b1}}) noise_cnt <= noise_cnt + W_CNT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (orphan) err_orphan <= 1'b1;
      if (ovf)    err_ovf    <= 1'b1;
    end
  end

endmodule
